// File: rtl/matrix_test_scheduler.sv
// Campaign controller: runs NUM_TESTS matrix-multiply tests, streams A and B into the SoC, tallies results.
// Optional watchdog in WAIT_DONE is enabled by defining MATRIX_TEST_SCHED_TIMEOUT_EN.
module matrix_test_scheduler #(
  parameter int MATRIX_SIZE    = 4,
  parameter int NUM_TESTS      = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  output logic        test_start_o,
  input  logic [15:0] sequence_i [MATRIX_SIZE],
  input  logic        sequence_valid_i,
  output logic        sequence_send_o,
  output logic [15:0] data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic        data_last_o,
  output logic        data_sel_o,
  input  logic        done_i,
  input  logic        result_ok_i,
  output logic        busy_o,
  output logic        finished_o,
  output logic [15:0] pass_cnt_o,
  output logic [15:0] fail_cnt_o,
  output logic        timeout_o
);

  localparam int IDX_W = $clog2(MATRIX_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_SIZE - 1);

  if (MATRIX_SIZE < 2 || NUM_TESTS < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("matrix_test_scheduler: illegal parameter value");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CAP_A, S_STR_A, S_ACK_A,
    S_CAP_B, S_STR_B, S_ACK_B, S_WAIT_DONE, S_NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      mat_buf [MATRIX_SIZE];
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_nxt;
  logic [31:0]      test_cnt_q;
  logic             last_test;
  logic             timed_out;

  assign idx_nxt   = idx_q + IDX_W'(1);
  assign last_test = (test_cnt_q == 32'(NUM_TESTS - 1));

`ifdef MATRIX_TEST_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  // A done_i on the limit cycle takes priority over the watchdog.
  assign timed_out = (state_q == S_WAIT_DONE) && !done_i &&
                     (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_ACK_B) wd_q <= '0;
      else if (state_q == S_WAIT_DONE && !done_i) wd_q <= wd_q + WD_W'(1);
      if (state_q == S_IDLE && run_i) timeout_q <= 1'b0;
      else if (timed_out) timeout_q <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    test_start_o    = 1'b0;
    sequence_send_o = 1'b0;
    data_valid_o    = 1'b0;
    busy_o          = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:      if (run_i) state_d = S_START;
      S_START: begin
        test_start_o = 1'b1;
        state_d      = S_CAP_A;
      end
      S_CAP_A:     if (sequence_valid_i) state_d = S_STR_A;
      S_STR_A: begin
        data_valid_o = 1'b1;
        if (data_ready_i && data_last_o) state_d = S_ACK_A;
      end
      S_ACK_A: begin
        sequence_send_o = 1'b1;
        state_d         = S_CAP_B;
      end
      S_CAP_B:     if (sequence_valid_i) state_d = S_STR_B;
      S_STR_B: begin
        data_valid_o = 1'b1;
        if (data_ready_i && data_last_o) state_d = S_ACK_B;
      end
      S_ACK_B: begin
        sequence_send_o = 1'b1;
        state_d         = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (done_i || timed_out) state_d = S_NEXT;
      S_NEXT:      state_d = last_test ? S_IDLE : S_START;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath: capture buffer, registered stream outputs, result tallies.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MATRIX_SIZE; i++) mat_buf[i] <= '0;
      idx_q       <= '0;
      data_o      <= '0;
      data_last_o <= 1'b0;
      data_sel_o  <= 1'b0;
      test_cnt_q  <= '0;
      pass_cnt_o  <= '0;
      fail_cnt_o  <= '0;
      finished_o  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (run_i) begin
          pass_cnt_o <= '0;
          fail_cnt_o <= '0;
          test_cnt_q <= '0;
          finished_o <= 1'b0;
        end
        S_CAP_A, S_CAP_B: if (sequence_valid_i) begin
          mat_buf     <= sequence_i;
          idx_q       <= '0;
          data_o      <= sequence_i[0];
          data_last_o <= 1'b0;
          data_sel_o  <= (state_q == S_CAP_B);
        end
        S_STR_A, S_STR_B: if (data_ready_i && !data_last_o) begin
          idx_q       <= idx_nxt;
          data_o      <= mat_buf[idx_nxt];
          data_last_o <= (idx_nxt == LAST_IDX);
        end
        S_WAIT_DONE: begin
          if (done_i) begin
            if (result_ok_i) begin
              if (pass_cnt_o != 16'hFFFF) pass_cnt_o <= pass_cnt_o + 16'd1;
            end else begin
              if (fail_cnt_o != 16'hFFFF) fail_cnt_o <= fail_cnt_o + 16'd1;
            end
          end else if (timed_out) begin
            if (fail_cnt_o != 16'hFFFF) fail_cnt_o <= fail_cnt_o + 16'd1;
          end
        end
        S_NEXT: begin
          test_cnt_q <= test_cnt_q + 32'd1;
          if (last_test) finished_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_test_scheduler.sv
// Self-checking bench for matrix_test_scheduler: sequencer/SoC models plus a queue-based expected stream.
module tb_matrix_test_scheduler;

  localparam int MS = 4;
  localparam int NT = 2;
  localparam int TC = 10;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        sel;
  } elem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_i;
  logic        test_start_o;
  logic [15:0] sequence_i [MS];
  logic        sequence_valid_i;
  logic        sequence_send_o;
  logic [15:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;
  logic        data_last_o;
  logic        data_sel_o;
  logic        done_i;
  logic        result_ok_i;
  logic        busy_o;
  logic        finished_o;
  logic [15:0] pass_cnt_o;
  logic [15:0] fail_cnt_o;
  logic        timeout_o;

  int tests_run = 0;
  int tests_failed = 0;
  elem_t exp_q[$];

  matrix_test_scheduler #(
    .MATRIX_SIZE(MS), .NUM_TESTS(NT), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run_i), .test_start_o(test_start_o),
    .sequence_i(sequence_i), .sequence_valid_i(sequence_valid_i),
    .sequence_send_o(sequence_send_o), .data_o(data_o), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .data_last_o(data_last_o), .data_sel_o(data_sel_o),
    .done_i(done_i), .result_ok_i(result_ok_i), .busy_o(busy_o),
    .finished_o(finished_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic fillSequence(input logic [15:0] value, input bit randomize);
    for (int i = 0; i < MS; i++) sequence_i[i] = randomize ? 16'($urandom) : value;
  endtask

  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  // ok_mode: 0 random, 1 all pass, 2 pass then fail.
  task automatic applyStimulus(input int ready_mode, input bit directed, input bit abort_b,
                               input int ok_mode, input int never_done_test, input int race_test);
    logic [15:0] mat_a [NT][MS];
    logic [15:0] mat_b [NT][MS];
    bit          ok [NT];
    int          dly [NT];
    int          exp_pass, exp_fail, phase, t, cnt, starts, sends, valid_samples, pk, b_xfers;
    bit          exp_to, stall, finished_seen, send_seen;
    elem_t       held, e;
    logic [15:0] prev_fail;
    int          pat [4];
    pat = '{1, 0, 0, 1};

    exp_q.delete();
    exp_pass = 0; exp_fail = 0; exp_to = 1'b0;
    for (int ti = 0; ti < NT; ti++) begin
      for (int i = 0; i < MS; i++) begin
        mat_a[ti][i] = (directed && ti == 0) ? 16'(i + 1) : 16'($urandom);
        mat_b[ti][i] = (directed && ti == 0) ? 16'(i + 5) : 16'($urandom);
      end
      ok[ti]  = (ok_mode == 1) ? 1'b1 : (ok_mode == 2) ? (ti == 0) : 1'($urandom_range(0, 1));
      dly[ti] = (ti == never_done_test) ? 100000 : (ti == race_test) ? TC : $urandom_range(1, 5);
      for (int i = 0; i < MS; i++) exp_q.push_back('{mat_a[ti][i], i == MS - 1, 1'b0});
      for (int i = 0; i < MS; i++) exp_q.push_back('{mat_b[ti][i], i == MS - 1, 1'b1});
`ifdef MATRIX_TEST_SCHED_TIMEOUT_EN
      if (dly[ti] > TC) begin
        exp_fail++;
        exp_to = 1'b1;
        continue;
      end
`endif
      if (ok[ti]) exp_pass++;
      else        exp_fail++;
    end

    phase = 0; t = 0; cnt = 0; starts = 0; sends = 0; valid_samples = 0; pk = 0; b_xfers = 0;
    stall = 1'b0; finished_seen = 1'b0; held = '0; prev_fail = '0;
    @(posedge clk); #1;
    run_i = 1'b1;

    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk); #1;
      run_i = 1'b0;
      done_i = 1'b0;
      result_ok_i = 1'($urandom_range(0, 1));
      if (cyc == 0) begin
        checkOutput("run_clears_counts", {finished_o, timeout_o, pass_cnt_o, fail_cnt_o}, 0);
        checkOutput("busy_after_run", busy_o, 1);
      end
      if (stall) begin
        checkOutput("hold_valid", data_valid_o, 1);
        checkOutput("hold_payload", {data_o, data_last_o, data_sel_o}, held);
      end
      if (finished_o) begin
        finished_seen = 1'b1;
        break;
      end
      if (data_valid_o) valid_samples++;

      if (abort_b && data_valid_o && data_sel_o && b_xfers >= 2) begin
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_stream_outs", {data_valid_o, data_last_o, data_sel_o, data_o}, 0);
        checkOutput("rst_ctrl_outs", {busy_o, sequence_send_o, test_start_o, finished_o}, 0);
        checkOutput("rst_counts", {pass_cnt_o, fail_cnt_o}, 0);
        sequence_valid_i = 1'b0; data_ready_i = 1'b0; run_i = 1'b0; done_i = 1'b0;
        @(negedge clk) rst = 1'b0;
        send_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          send_seen = send_seen | sequence_send_o | busy_o;
        end
        checkOutput("no_send_after_reset", send_seen, 0);
        return;
      end

      if (sequence_send_o) sends++;
      if (test_start_o) begin
        starts++;
        t = (starts <= NT) ? starts - 1 : NT - 1;
        phase = 1;
        cnt = $urandom_range(0, 3);
      end
      case (phase)
        1: if (cnt == 0) begin
          for (int i = 0; i < MS; i++) sequence_i[i] = mat_a[t][i];
          sequence_valid_i = 1'b1;
          phase = 2;
        end else cnt--;
        2: if (sequence_send_o) begin
          sequence_valid_i = 1'b0;
          fillSequence(16'h0, 1'b1);
          phase = 3;
          cnt = $urandom_range(0, 3);
        end else if (data_valid_o) fillSequence(16'h9, 1'b0);
        3: if (cnt == 0) begin
          for (int i = 0; i < MS; i++) sequence_i[i] = mat_b[t][i];
          sequence_valid_i = 1'b1;
          phase = 4;
        end else cnt--;
        4: if (sequence_send_o) begin
          sequence_valid_i = 1'b0;
          fillSequence(16'h0, 1'b1);
          phase = 5;
          cnt = 0;
        end else if (data_valid_o) fillSequence(16'h0, 1'b1);
        5: begin
          cnt++;
          if (cnt == 1) run_i = 1'b1;
          if (cnt == dly[t]) begin
            done_i = 1'b1;
            result_ok_i = ok[t];
          end
          if (fail_cnt_o != prev_fail && dly[t] > TC) begin
            checkOutput("timeout_latency", cnt, TC + 1);
            checkOutput("timeout_flag", timeout_o, 1);
          end
        end
        default: ;
      endcase
      prev_fail = fail_cnt_o;

      case (ready_mode)
        0:       data_ready_i = 1'b1;
        1:       data_ready_i = 1'(pat[pk % 4]);
        default: data_ready_i = 1'($urandom_range(0, 1));
      endcase
      pk++;
      if (data_valid_o && data_ready_i) begin
        if (data_sel_o) b_xfers++;
        if (exp_q.size() == 0) checkOutput("stream_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("stream_elem", {data_o, data_last_o, data_sel_o}, e);
        end
      end
      stall = data_valid_o && !data_ready_i;
      held  = '{data_o, data_last_o, data_sel_o};
    end

    checkOutput("campaign_in_budget", finished_seen, 1);
    checkOutput("pass_cnt", pass_cnt_o, exp_pass);
    checkOutput("fail_cnt", fail_cnt_o, exp_fail);
    checkOutput("timeout_o", timeout_o, exp_to);
    checkOutput("start_pulses", starts, NT);
    checkOutput("send_pulses", sends, 2 * NT);
    checkOutput("stream_leftover", exp_q.size(), 0);
    checkOutput("idle_at_end", busy_o, 0);
    if (ready_mode == 0) checkOutput("throughput", valid_samples, 2 * MS * NT);
    sequence_valid_i = 1'b0;
    data_ready_i = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; run_i = 1'b0; sequence_valid_i = 1'b0; data_ready_i = 1'b0;
    done_i = 1'b0; result_ok_i = 1'b0;
    fillSequence(16'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_stream", {data_valid_o, data_last_o, data_sel_o, data_o}, 0);
    checkOutput("reset_ctrl", {busy_o, finished_o, test_start_o, sequence_send_o, timeout_o}, 0);
    checkOutput("reset_counts", {pass_cnt_o, fail_cnt_o}, 0);

    applyStimulus(0, 1'b1, 1'b0, 1, -1, -1);
    applyStimulus(1, 1'b0, 1'b0, 2, -1, -1);
    applyStimulus(2, 1'b0, 1'b0, 0, -1, -1);
    applyStimulus(2, 1'b0, 1'b1, 0, -1, -1);
    applyStimulus(2, 1'b0, 1'b0, 0, -1, -1);
`ifdef MATRIX_TEST_SCHED_TIMEOUT_EN
    applyStimulus(2, 1'b0, 1'b0, 1, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
